// File: rtl/adpll_div_pkg.sv
// adpll_div_pkg: shared state encoding and ratio constants for the ADPLL feedback divider
package adpll_div_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int NDIV_MIN     = 2;
  localparam int NDIV_DEFAULT = 4;
endpackage

// File: rtl/frac_accum.sv
// frac_accum: FRAC_W-bit phase accumulator with carry-out and clear; built only with FREQ_DIV_FRAC_EN
`ifdef FREQ_DIV_FRAC_EN
module frac_accum #(
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);
  logic [FRAC_W-1:0] acc_q, acc_d, sum;
  always_comb begin
    {carry_o, sum} = {1'b0, acc_q} + {1'b0, frac_i};
    acc_d = clr_i ? '0 : add_i ? sum : acc_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
endmodule
`endif

// File: rtl/freq_divider_frac.sv
// freq_divider_frac: programmable clock divider with boundary-applied ratio updates.
// Define FREQ_DIV_FRAC_EN to add the frac_in port and first-order fractional-N dithering.
module freq_divider_frac
  import adpll_div_pkg::*;
#(
  parameter int NDIV_W       = 8,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_NDIV = NDIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NDIV_W-1:0] ndiv_in,
  input  logic              ndiv_valid,
`ifdef FREQ_DIV_FRAC_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  output logic              ndiv_ack,
  output logic              ndiv_err,
  output logic [NDIV_W-1:0] ndiv_active,
  output logic              div_out,
  output logic              div_tick
);
  localparam logic [NDIV_W-1:0] N_MIN = NDIV_W'(NDIV_MIN);
  localparam logic [NDIV_W-1:0] N_DEF = NDIV_W'(DEFAULT_NDIV);
  state_e            state_q, state_d;
  logic [NDIV_W:0]   cnt_q, cnt_d, len_q, len_d, half;
  logic [NDIV_W-1:0] active_q, active_d, pend_q, pend_d, n_next;
  logic              pend_vld_q, pend_vld_d, out_q, out_d, tick_q, tick_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic              req_ok, req_bad, boundary, carry;
  if (DEFAULT_NDIV < NDIV_MIN || FRAC_W < 1) begin : g_bad_param
    $error("freq_divider_frac: DEFAULT_NDIV must be >= 2 and FRAC_W >= 1");
  end
  assign req_ok   = ndiv_valid && ndiv_in >= N_MIN;
  assign req_bad  = ndiv_valid && !req_ok;
  assign boundary = state_q == RUN && cnt_q == len_q - 1'b1;
  // a request landing on the boundary edge itself bypasses the pending register
  assign n_next   = req_ok ? ndiv_in : pend_vld_q ? pend_q : active_q;
`ifdef FREQ_DIV_FRAC_EN
  frac_accum #(.FRAC_W(FRAC_W)) u_frac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_d == IDLE),
    .add_i   (boundary && enable),
    .frac_i  (frac_in),
    .carry_o (carry)
  );
`else
  assign carry = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = req_bad;
    err_d      = req_bad;
    if (state_q == IDLE) begin
      active_d = req_ok ? ndiv_in : active_q;
      ack_d    = ndiv_valid;
      state_d  = enable ? RUN : IDLE;
      len_d    = (NDIV_W+1)'(active_d);
    end else if (boundary) begin
      active_d   = n_next;
      pend_vld_d = 1'b0;
      ack_d      = ndiv_valid;
      state_d    = enable ? RUN : IDLE;
      cnt_d      = '0;
      len_d      = (NDIV_W+1)'(n_next) + (NDIV_W+1)'(carry);
    end else begin
      cnt_d      = cnt_q + 1'b1;
      pend_d     = req_ok ? ndiv_in : pend_q;
      pend_vld_d = pend_vld_q | req_ok;
      ack_d      = req_bad | (cnt_d == len_q - 1'b1 && pend_vld_d);
    end
    half   = (len_d + 1'b1) >> 1;
    out_d  = state_d == RUN && cnt_d < half;
    tick_d = state_d == RUN && cnt_d == '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= (NDIV_W+1)'(N_DEF);
      active_q   <= N_DEF;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  assign ndiv_active = active_q;
  assign div_out     = out_q;
  assign div_tick    = tick_q;
  assign ndiv_ack    = ack_q;
  assign ndiv_err    = err_q;
endmodule
